// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_fas_bit_cell.sv
// Combinational 1-bit full adder/subtractor: sum/difference and carry/borrow out.
module fas_bit_cell
  import serial_add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic sel,
  output logic sd,
  output logic cb
);

  always_comb begin
    sd = a ^ b ^ c;
    if (sel == SEL_SUB) cb = (~a & b) | (c & ~(a ^ b));
    else                cb = (a & b) | (c & (a ^ b));
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one bit per clock.
// Define SERIAL_ADD_SUB_OVF_EN to build the signed-overflow flag.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             ovf
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             c_q, c_d;
  logic             cb_q, cb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept, last_bit;
  logic             cell_sd, cell_cb;

  fas_bit_cell u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .c  (c_q),
    .sel(sel_q),
    .sd (cell_sd),
    .cb (cell_cb)
  );

  always_comb begin
    accept   = (state_q == IDLE) && start;
    last_bit = (state_q == RUN) && (cnt_q == LAST);
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    c_d      = c_q;
    cb_d     = cb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          sel_d   = sel;
          cnt_d   = '0;
          c_d     = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        result_d = {cell_sd, result_q[WIDTH-1:1]};
        c_d      = cell_cb;
        // Counter parks at LAST on the final bit so it never wraps.
        if (cnt_q == LAST) begin
          cb_d    = cell_cb;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      c_q      <= 1'b0;
      cb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      c_q      <= c_d;
      cb_q     <= cb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    // The bit produced on the final edge is the result MSB.
    if (last_bit) begin
      if (sel_q == SEL_SUB) ovf_d = (a_msb_q != b_msb_q) && (cell_sd != a_msb_q);
      else                  ovf_d = (a_msb_q == b_msb_q) && (cell_sd != a_msb_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb ovf = ovf_q;
`else
  always_comb ovf = 1'b0;
`endif

  always_comb begin
    busy   = busy_q;
    done   = done_q;
    result = result_q;
    cb     = cb_q;
  end

endmodule
